alu_regfile: RTL and testbench

- Integer datapath core pairing a 14-operation 32-bit combinational ALU with a 32x32 general-purpose register file (2 read ports, 1 write port).
- Sits in the execute/decode stage of the RV32-style CPU.
- The ALU and register file share no internal connection; operands and results are wired externally.
- The ALU is purely combinational; the register file has synchronous writes and combinational reads.

---
 rtl/alu_regfile_if.sv | 30 +++
 rtl/alu_regfile.sv | 79 +++++++
 tb/tb_alu_regfile.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_if.sv
// Bus bundle for the execute-stage datapath: register file ports and ALU operand/result.
// The master side drives operands, addresses and write data; the slave side is the datapath.
interface alu_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wen;
    logic [ADDR_W-1:0] regWAddr;
    logic [DATA_W-1:0] regWData;
    logic [ADDR_W-1:0] regRAddr1;
    logic [ADDR_W-1:0] regRAddr2;
    logic [DATA_W-1:0] regRData1;
    logic [DATA_W-1:0] regRData2;
    logic [DATA_W-1:0] alu_data1_i;
    logic [DATA_W-1:0] alu_data2_i;
    logic [3:0]        alu_op_i;
    logic [DATA_W-1:0] alu_result_o;

    modport master (
        output wen, regWAddr, regWData, regRAddr1, regRAddr2,
        output alu_data1_i, alu_data2_i, alu_op_i,
        input  regRData1, regRData2, alu_result_o
    );

    modport slave (
        input  wen, regWAddr, regWData, regRAddr1, regRAddr2,
        input  alu_data1_i, alu_data2_i, alu_op_i,
        output regRData1, regRData2, alu_result_o
    );
endinterface

// File: rtl/alu_regfile.sv
// Combinational 14-op 32-bit ALU alongside a 32x32 register file (2R/1W, x0 hardwired to zero).
// The two halves share nothing internally; operands and results are routed outside this block.
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    alu_regfile_if.slave     bus
);

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_SLL  = 4'h2,
        OP_SLT  = 4'h3,
        OP_SLTU = 4'h4,
        OP_XOR  = 4'h5,
        OP_SRL  = 4'h6,
        OP_SRA  = 4'h7,
        OP_OR   = 4'h8,
        OP_AND  = 4'h9,
        OP_EQ   = 4'hA,
        OP_NEQ  = 4'hB,
        OP_GE   = 4'hC,
        OP_GEU  = 4'hD
    } alu_op_e;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] result;

    assign a     = bus.alu_data1_i;
    assign b     = bus.alu_data2_i;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (bus.alu_op_i)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> shamt);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_EQ:   result = {{(DATA_W-1){1'b0}}, (a == b)};
            OP_NEQ:  result = {{(DATA_W-1){1'b0}}, (a != b)};
            OP_GE:   result = {{(DATA_W-1){1'b0}}, ($signed(a) >= $signed(b))};
            OP_GEU:  result = {{(DATA_W-1){1'b0}}, (a >= b)};
            default: result = '0;
        endcase
    end

    assign bus.alu_result_o = result;

    logic [DATA_W-1:0] regs_q [NREG];

    // Entry 0 is never written, so it stays at its cleared value; reads mask it anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wen && (bus.regWAddr != '0)) begin
            regs_q[bus.regWAddr] <= bus.regWData;
        end
    end

    assign bus.regRData1 = (bus.regRAddr1 == '0) ? '0 : regs_q[bus.regRAddr1];
    assign bus.regRData2 = (bus.regRAddr2 == '0) ? '0 : regs_q[bus.regRAddr2];

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile: ALU op vectors plus register file write/read, x0, wen and async reset.
module tb_alu_regfile;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    alu_regfile_if bus ();

    alu_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_alu_vec(input string name, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
        bus.alu_op_i    = op;
        bus.alu_data1_i = a;
        bus.alu_data2_i = b;
        #1;
        tests++;
        if (bus.alu_result_o !== exp) begin
            fails++;
            $display("FAIL %s op=%h a=%h b=%h got %h expected %h", name, op, a, b, bus.alu_result_o, exp);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.wen       = 1'b0;
        bus.regWAddr  = '0;
        bus.regWData  = '0;
        bus.regRAddr1 = 5'd1;
        bus.regRAddr2 = 5'd31;
        bus.alu_op_i  = 4'h0;
        bus.alu_data1_i = '0;
        bus.alu_data2_i = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.regRData1 !== 32'h0 || bus.regRData2 !== 32'h0) begin
            fails++;
            $display("FAIL reset_state got %h/%h expected 0/0", bus.regRData1, bus.regRData2);
        end
    endtask

    task automatic test_alu_arith();
        run_alu_vec("add",      4'h0, 32'h2,        32'h20,       32'h22);
        run_alu_vec("add_wrap", 4'h0, 32'hffffffff, 32'h2,        32'h1);
        run_alu_vec("sub",      4'h1, 32'h20,       32'h10,       32'h10);
        run_alu_vec("sub_wrap", 4'h1, 32'h0,        32'h1,        32'hffffffff);
        run_alu_vec("and",      4'h9, 32'haaaa5555, 32'hffff0000, 32'haaaa0000);
        run_alu_vec("or",       4'h8, 32'haaaa5555, 32'hffff0000, 32'hffff5555);
        run_alu_vec("xor",      4'h5, 32'h12345678, 32'h87654321, 32'h95511559);
    endtask

    task automatic test_alu_shift();
        run_alu_vec("sll",      4'h2, 32'h1,        32'h2,        32'h4);
        run_alu_vec("srl",      4'h6, 32'h80000000, 32'h1,        32'h40000000);
        run_alu_vec("sra",      4'h7, 32'h80000000, 32'h1,        32'hc0000000);
        run_alu_vec("sra_pos",  4'h7, 32'h40000000, 32'h4,        32'h04000000);
        run_alu_vec("sll_mask", 4'h2, 32'h1,        32'h21,       32'h2);
        run_alu_vec("srl_31",   4'h6, 32'h80000000, 32'h1f,       32'h1);
    endtask

    task automatic test_alu_cmp();
        run_alu_vec("slt",       4'h3, 32'h5,        32'ha,        32'h1);
        run_alu_vec("slt_false", 4'h3, 32'ha,        32'h5,        32'h0);
        run_alu_vec("sltu",      4'h4, 32'hfffffffe, 32'h1,        32'h0);
        run_alu_vec("slt_neg",   4'h3, 32'hfffffffe, 32'h1,        32'h1);
        run_alu_vec("eq",        4'ha, 32'hcafef00d, 32'hcafef00d, 32'h1);
        run_alu_vec("eq_false",  4'ha, 32'h1,        32'h2,        32'h0);
        run_alu_vec("neq",       4'hb, 32'h12345678, 32'h87654321, 32'h1);
        run_alu_vec("ge",        4'hc, 32'h2,        32'h2,        32'h1);
        run_alu_vec("ge_neg",    4'hc, 32'hffffffff, 32'h1,        32'h0);
        run_alu_vec("geu",       4'hd, 32'h2,        32'h2,        32'h1);
        run_alu_vec("geu_big",   4'hd, 32'hffffffff, 32'h1,        32'h1);
        run_alu_vec("op_e",      4'he, 32'hffffffff, 32'hffffffff, 32'h0);
        run_alu_vec("op_f",      4'hf, 32'h12345678, 32'h1,        32'h0);
    endtask

    task automatic test_reg_rw();
        @(negedge clk);
        bus.wen = 1'b1; bus.regWAddr = 5'd1; bus.regWData = 32'h12345678;
        bus.regRAddr1 = 5'd1; bus.regRAddr2 = 5'd0;
        #1;
        tests++;
        if (bus.regRData1 !== 32'h0) begin
            fails++;
            $display("FAIL no_bypass got %h expected %h", bus.regRData1, 32'h0);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.regRData1 !== 32'h12345678 || bus.regRData2 !== 32'h0) begin
            fails++;
            $display("FAIL write_x1 got %h/%h expected 12345678/0", bus.regRData1, bus.regRData2);
        end
        @(negedge clk);
        bus.regWAddr = 5'd2; bus.regWData = 32'hdeadbeef; bus.regRAddr2 = 5'd2;
        @(posedge clk); #1;
        bus.wen = 1'b0;
        tests++;
        if (bus.regRData1 !== 32'h12345678 || bus.regRData2 !== 32'hdeadbeef) begin
            fails++;
            $display("FAIL write_x2 got %h/%h expected 12345678/deadbeef", bus.regRData1, bus.regRData2);
        end
        bus.regRAddr1 = 5'd2;
        #1;
        tests++;
        if (bus.regRData1 !== 32'hdeadbeef || bus.regRData2 !== 32'hdeadbeef) begin
            fails++;
            $display("FAIL same_addr got %h/%h expected deadbeef/deadbeef", bus.regRData1, bus.regRData2);
        end
    endtask

    task automatic test_x0_wen();
        @(negedge clk);
        bus.wen = 1'b1; bus.regWAddr = 5'd0; bus.regWData = 32'hffffffff;
        bus.regRAddr1 = 5'd0; bus.regRAddr2 = 5'd0;
        @(posedge clk); #1;
        tests++;
        if (bus.regRData1 !== 32'h0 || bus.regRData2 !== 32'h0) begin
            fails++;
            $display("FAIL x0_write got %h/%h expected 0/0", bus.regRData1, bus.regRData2);
        end
        @(negedge clk);
        bus.wen = 1'b0; bus.regWAddr = 5'd1; bus.regWData = 32'h0; bus.regRAddr1 = 5'd1;
        @(posedge clk); #1;
        tests++;
        if (bus.regRData1 !== 32'h12345678) begin
            fails++;
            $display("FAIL wen_low got %h expected 12345678", bus.regRData1);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.regRAddr1 = 5'd1; bus.regRAddr2 = 5'd2;
        #1 reset = 1'b0;
        #1;
        tests++;
        if (bus.regRData1 !== 32'h0 || bus.regRData2 !== 32'h0) begin
            fails++;
            $display("FAIL async_clear got %h/%h expected 0/0", bus.regRData1, bus.regRData2);
        end
        bus.wen = 1'b1; bus.regWAddr = 5'd3; bus.regWData = 32'ha5a5a5a5; bus.regRAddr1 = 5'd3;
        @(posedge clk); #1;
        tests++;
        if (bus.regRData1 !== 32'h0 || bus.regRData2 !== 32'h0) begin
            fails++;
            $display("FAIL write_in_reset got %h/%h expected 0/0", bus.regRData1, bus.regRData2);
        end
        @(negedge clk);
        bus.wen = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.regRData1 !== 32'h0 || bus.regRData2 !== 32'h0) begin
            fails++;
            $display("FAIL post_reset got %h/%h expected 0/0", bus.regRData1, bus.regRData2);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_alu_arith();
        test_alu_shift();
        test_alu_cmp();
        test_reg_rw();
        test_x0_wen();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout bench did not complete in time");
        $fatal(1);
    end

endmodule
